// File: rtl/spw_babasu_pio_pkg.sv
// Shared definitions for the spw_babasu PIO family: register addresses,
// pulse-engine state encoding and the PULSE_LEN register width.
package spw_babasu_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE     = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    localparam int PULSE_LEN_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/spw_babasu_pulse_gen.sv
// One-shot strobe engine: a start ORs mask into the pulse vector and (re)loads
// the down-counter; the vector clears once the counter has run out.
module spw_babasu_pulse_gen
    import spw_babasu_pio_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_mask,
    input  logic [PULSE_LEN_W-1:0] i_len,
    output logic [WIDTH-1:0]       o_pulse
);

    pulse_state_e           r_state, w_state_nxt;
    logic [PULSE_LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]       r_pulse, w_pulse_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // A restart takes priority over expiry, so an in-flight strobe is extended.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = r_pulse;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_pulse_nxt = i_mask;
                    w_cnt_nxt   = i_len;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (i_start) begin
                    w_pulse_nxt = r_pulse | i_mask;
                    w_cnt_nxt   = i_len;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_pulse_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pulse_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/spw_babasu_ctrl_out.sv
// Avalon-MM control output PIO: static DATA bits plus timed strobes.
// Optional OUTSET/OUTCLEAR registers are built when SPW_CTRL_OUT_BITSET_EN is defined.
module spw_babasu_ctrl_out
    import spw_babasu_pio_pkg::*;
#(
    parameter int          WIDTH           = 11,
    parameter logic [31:0] RESET_VALUE     = 32'd0,
    parameter int          PULSE_LEN_RESET = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] pulse_port
);

    logic                   w_we;
    logic [WIDTH-1:0]       w_wd;
    logic                   w_start;
    logic [WIDTH-1:0]       w_pulse;
    logic [31:0]            w_rmux;
    logic [WIDTH-1:0]       r_data;
    logic [PULSE_LEN_W-1:0] r_pulse_len;
    logic [31:0]            r_rdata;

    assign w_we    = chipselect & ~write_n;
    assign w_wd    = writedata[WIDTH-1:0];
    assign w_start = w_we && (address == ADDR_PULSE) && (w_wd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= RESET_VALUE[WIDTH-1:0];
            r_pulse_len <= PULSE_LEN_W'(PULSE_LEN_RESET);
        end else if (w_we) begin
            case (address)
                ADDR_DATA:      r_data      <= w_wd;
                ADDR_PULSE_LEN: r_pulse_len <= writedata[PULSE_LEN_W-1:0];
`ifdef SPW_CTRL_OUT_BITSET_EN
                ADDR_OUTSET:    r_data      <= r_data | w_wd;
                ADDR_OUTCLEAR:  r_data      <= r_data & ~w_wd;
`endif
                default: ;
            endcase
        end
    end

    spw_babasu_pulse_gen #(
        .WIDTH (WIDTH)
    ) u_pulse_gen (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_mask  (w_wd),
        .i_len   (r_pulse_len),
        .o_pulse (w_pulse)
    );

    // Readback samples pre-write state, so a same-cycle write is seen next read.
    always_comb begin
        w_rmux = '0;
        case (address)
            ADDR_DATA:      w_rmux = 32'(r_data);
            ADDR_PULSE:     w_rmux = 32'(w_pulse);
            ADDR_PULSE_LEN: w_rmux = 32'(r_pulse_len);
            default:        w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rdata <= '0;
        else       r_rdata <= w_rmux;
    end

    assign readdata   = r_rdata;
    assign out_port   = r_data;
    assign pulse_port = w_pulse;

endmodule

// File: tb/tb_spw_babasu_ctrl_out.sv
// Self-checking bench for spw_babasu_ctrl_out: directed scenarios with literal
// expectations, then randomized bus traffic against a timestamp-based model.
module tb_spw_babasu_ctrl_out;

    localparam int WIDTH = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] pulse_port;

    always #5 clk = ~clk;

    spw_babasu_ctrl_out #(
        .WIDTH           (WIDTH),
        .RESET_VALUE     (32'd0),
        .PULSE_LEN_RESET (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_port (pulse_port)
    );

`ifdef SPW_CTRL_OUT_BITSET_EN
    localparam bit BITSET = 1'b1;
`else
    localparam bit BITSET = 1'b0;
`endif

    // Reference state: strobes are tracked by the edge index at which they lapse.
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_pulse;
    logic [7:0]       m_len;
    logic [31:0]      m_rd;
    longint           cyc;
    longint           m_end;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out   = '0;
        m_pulse = '0;
        m_len   = 8'd3;
        m_rd    = '0;
        m_end   = 0;
    endtask

    // Advances the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic             we;
        logic [WIDTH-1:0] wd;
        we = chipselect && !write_n;
        wd = writedata[WIDTH-1:0];
        case (address)
            3'd0:    m_rd = 32'(m_out);
            3'd2:    m_rd = 32'(m_pulse);
            3'd3:    m_rd = 32'(m_len);
            default: m_rd = 32'd0;
        endcase
        if (we && address == 3'd2 && wd != '0) begin
            m_pulse = m_pulse | wd;
            m_end   = cyc + longint'(m_len) + 1;
        end else if (m_pulse != '0 && cyc == m_end) begin
            m_pulse = '0;
        end
        if (we) begin
            if (address == 3'd0) m_out = wd;
            else if (address == 3'd3) m_len = writedata[7:0];
            else if (BITSET && address == 3'd4) m_out = m_out | wd;
            else if (BITSET && address == 3'd5) m_out = m_out & ~wd;
        end
        cyc++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("out_port", 32'(out_port), 32'(m_out));
        check("pulse_port", 32'(pulse_port), 32'(m_pulse));
        check("readdata", readdata, m_rd);
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
        idle_bus();
    endtask

    task automatic rd_lit(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a;
        idle_bus();
        step();
        check(name, readdata, exp);
    endtask

    initial begin
        int hi;
        logic [2:0]  a;
        logic [31:0] d;

        cyc = 0;
        reset = 1'b1;
        address = '0;
        idle_bus();
        model_reset();
        #12;
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_pulse", 32'(pulse_port), 32'h0);
        check("rst_rd", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        rd_lit(3'd0, 32'h0, "rd_data_rst");
        rd_lit(3'd2, 32'h0, "rd_pulse_rst");
        rd_lit(3'd3, 32'h3, "rd_len_rst");

        wr(3'd0, 32'h7FF);
        check("data_7ff", 32'(out_port), 32'h7FF);
        wr(3'd0, 32'hFFFFF005);
        check("data_005", 32'(out_port), 32'h005);
        rd_lit(3'd0, 32'h005, "rd_data_005");

        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h00F);
        check("outset", 32'(out_port), BITSET ? 32'h0FF : 32'h0F0);
        wr(3'd5, 32'h030);
        check("outclear", 32'(out_port), BITSET ? 32'h0CF : 32'h0F0);
        rd_lit(3'd4, 32'h0, "rd_outset_rsvd");

        wr(3'd3, 32'h0);
        wr(3'd2, 32'h001);
        check("len0_hi", 32'(pulse_port), 32'h001);
        step();
        check("len0_lo", 32'(pulse_port), 32'h000);

        wr(3'd3, 32'h5);
        wr(3'd2, 32'h400);
        hi = pulse_port[10] ? 1 : 0;
        repeat (12) begin
            step();
            if (pulse_port[10]) hi++;
        end
        check("len5_cycles", 32'(hi), 32'd6);

        wr(3'd2, 32'h001);
        repeat (3) step();
        check("pre_restart", 32'(pulse_port), 32'h001);
        wr(3'd2, 32'h002);
        hi = (pulse_port == 11'h003) ? 1 : 0;
        repeat (10) begin
            step();
            if (pulse_port == 11'h003) hi++;
        end
        check("restart_cycles", 32'(hi), 32'd6);
        check("restart_end", 32'(pulse_port), 32'h0);

        wr(3'd2, 32'h000);
        check("zero_wr", 32'(pulse_port), 32'h0);
        step();
        check("zero_wr2", 32'(pulse_port), 32'h0);

        wr(3'd0, 32'h123);
        wr(3'd2, 32'h007);
        step();
        check("pre_reset_pulse", 32'(pulse_port), 32'h007);
        #2;
        reset = 1'b1;
        #1;
        check("async_out", 32'(out_port), 32'h0);
        check("async_pulse", 32'(pulse_port), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_lit(3'd3, 32'h3, "rd_len_after_rst");
        rd_lit(3'd2, 32'h0, "rd_pulse_after_rst");

        repeat (3000) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3) d = d & 32'h7;
            if (a == 3'd2 && $urandom_range(0, 3) == 0) d = 32'h0;
            address    = a;
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            writedata  = d;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
